// File: rtl/timer_pkg.sv
// Shared register map, CTRL layout and byte-lane helper for the bus_timer slave.
package timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_AUTO_BIT     = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;
  localparam int CTRL_PRESCALE_LSB = 8;

  localparam int STATUS_EXPIRED_BIT = 0;
  localparam int STATUS_RUNNING_BIT = 1;

  // Mirrors the CTRL word bit-for-bit so the struct can be cast to/from the bus word.
  typedef struct packed {
    logic [23:0] prescale;
    logic [4:0]  rsvd;
    logic        irq_en;
    logic        auto_rl;
    logic        en;
  } ctrl_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock by PRESCALE+1 while enabled, emitting a one-cycle evaluation strobe.
module timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  strobe
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

  always_comb begin
    strobe = en && (pcnt_q == prescale);
    if (!en || clr || strobe) pcnt_d = '0;
    else                      pcnt_d = pcnt_q + PRESCALE_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer: register file, bus decode and reload/one-shot counter.
module bus_timer
  import timer_pkg::*;
#(
  parameter int          PRESCALE_W = 8,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [3:0]  rd_be,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_gnt,
  input  logic        wr_req,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_gnt,
  output logic        irq,
  output logic        tick
);

  localparam logic [23:0] PS_MASK  = 24'((64'd1 << PRESCALE_W) - 64'd1);
  localparam logic [31:0] CNT_MASK = 32'((64'd1 << CNT_W) - 64'd1);

  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             expired_q, expired_d;
  logic             irq_q, irq_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [31:0]      rd_word, wr_word;
  logic             strobe, hw_expire, ctrl_wr;
  logic             unused_bits;

  assign unused_bits = ^{rd_be, rd_addr[31:4], rd_addr[1:0], wr_addr[31:4], wr_addr[1:0]};

  assign rd_gnt  = rd_req;
  assign wr_gnt  = wr_req;
  assign rd_data = rd_data_q;
  assign irq     = irq_q;
  assign tick    = hw_expire;
  assign ctrl_wr = wr_req && (wr_addr[3:2] == REG_CTRL);

  timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl_q.en),
    .clr      (ctrl_wr),
    .prescale (ctrl_q.prescale[PRESCALE_W-1:0]),
    .strobe   (strobe)
  );

  always_comb begin
    rd_word = '0;
    case (rd_addr[3:2])
      REG_CTRL:  rd_word = ctrl_q;
      REG_LOAD:  rd_word = 32'(load_q);
      REG_COUNT: rd_word = 32'(count_q);
      default: begin
        rd_word[STATUS_EXPIRED_BIT] = expired_q;
        rd_word[STATUS_RUNNING_BIT] = ctrl_q.en;
      end
    endcase
    rd_data_d = rd_req ? rd_word : rd_data_q;
  end

  // Hardware update first; a software write in the same cycle then overrides it,
  // except that a hardware expiry always survives a simultaneous W1C.
  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    expired_d = expired_q;
    hw_expire = 1'b0;
    wr_word   = '0;

    if (strobe) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        hw_expire = 1'b1;
        if (ctrl_q.auto_rl) count_d   = load_q;
        else                ctrl_d.en = 1'b0;
      end
    end

    if (wr_req) begin
      case (wr_addr[3:2])
        REG_CTRL: begin
          wr_word         = be_merge(ctrl_d, wr_data, wr_be);
          ctrl_d          = ctrl_t'(wr_word);
          ctrl_d.prescale = ctrl_d.prescale & PS_MASK;
          ctrl_d.rsvd     = '0;
        end
        REG_LOAD: begin
          wr_word = be_merge(32'(load_q), wr_data, wr_be) & CNT_MASK;
          load_d  = wr_word[CNT_W-1:0];
        end
        REG_COUNT: begin
          wr_word = be_merge(32'(count_d), wr_data, wr_be) & CNT_MASK;
          count_d = wr_word[CNT_W-1:0];
        end
        default: begin
          if (wr_be[0] && wr_data[STATUS_EXPIRED_BIT]) expired_d = 1'b0;
        end
      endcase
    end

    if (hw_expire) expired_d = 1'b1;

    irq_d = expired_q & ctrl_q.irq_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      load_q    <= RESET_LOAD[CNT_W-1:0];
      count_q   <= '0;
      expired_q <= 1'b0;
      irq_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      irq_q     <= irq_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: cycle-level reference model, directed scenarios and random traffic.
module tb_bus_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req, rd_gnt, wr_gnt, irq, tick;
  logic [3:0]  rd_be, wr_be;
  logic [31:0] rd_addr, wr_addr, wr_data, rd_data;

  int total = 0;
  int bad   = 0;

  bus_timer dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_be(rd_be), .rd_addr(rd_addr), .rd_data(rd_data), .rd_gnt(rd_gnt),
    .wr_req(wr_req), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .irq(irq), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: timer state as plain numbers.
  bit          m_en, m_auto, m_irqen, m_exp, m_irq;
  int unsigned m_ps, m_pcnt;
  bit [31:0]   m_load, m_count, m_rd;

  function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] be);
    bit [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic bit [31:0] m_read(input bit [1:0] a);
    case (a)
      2'd0:    return (32'(m_ps) << 8) | {29'b0, m_irqen, m_auto, m_en};
      2'd1:    return m_load;
      2'd2:    return m_count;
      default: return {30'b0, m_en, m_exp};
    endcase
  endfunction

  function automatic bit m_tick();
    return m_en && (m_pcnt == m_ps) && (m_count == 0);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit          strobe, fire, n_en, n_auto, n_irqen, n_exp;
    int unsigned n_ps, n_pcnt;
    bit [31:0]   n_count, n_load, w;
    if (rst) begin
      m_en = 0; m_auto = 0; m_irqen = 0; m_exp = 0; m_irq = 0;
      m_ps = 0; m_pcnt = 0; m_load = 0; m_count = 0; m_rd = 0;
    end else begin
      strobe  = m_en && (m_pcnt == m_ps);
      fire    = strobe && (m_count == 0);
      n_en = m_en; n_auto = m_auto; n_irqen = m_irqen; n_exp = m_exp;
      n_ps = m_ps; n_count = m_count; n_load = m_load;
      n_pcnt  = (!m_en || strobe) ? 0 : m_pcnt + 1;
      if (rd_req) m_rd = m_read(rd_addr[3:2]);
      m_irq = m_exp && m_irqen;
      if (strobe) begin
        if (m_count > 0) n_count = m_count - 1;
        else begin
          n_exp = 1;
          if (m_auto) n_count = m_load;
          else        n_en = 0;
        end
      end
      if (wr_req) begin
        case (wr_addr[3:2])
          2'd0: begin
            w = merge((32'(n_ps) << 8) | {29'b0, n_irqen, n_auto, n_en}, wr_data, wr_be);
            n_en = w[0]; n_auto = w[1]; n_irqen = w[2];
            n_ps = (w >> 8) & 32'hFF;
            n_pcnt = 0;
          end
          2'd1: n_load  = merge(m_load, wr_data, wr_be);
          2'd2: n_count = merge(n_count, wr_data, wr_be);
          default: if (wr_be[0] && wr_data[0] && !fire) n_exp = 0;
        endcase
      end
      m_en = n_en; m_auto = n_auto; m_irqen = n_irqen; m_exp = n_exp;
      m_ps = n_ps; m_pcnt = n_pcnt; m_count = n_count; m_load = n_load;
    end
  end

  always @(negedge clk) begin
    chk("rd_gnt", rd_gnt, rd_req);
    chk("wr_gnt", wr_gnt, wr_req);
    chk("rd_data", rd_data, m_rd);
    chk("irq", irq, m_irq);
    chk("tick", tick, m_tick());
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input bit [1:0] a, input bit [31:0] d, input bit [3:0] be);
    wr_req = 1; wr_addr = 32'h0003_2000 | (32'(a) << 2); wr_data = d; wr_be = be;
    step();
    wr_req = 0; wr_data = $urandom; wr_be = 4'($urandom);
  endtask

  task automatic rd(input bit [1:0] a, output bit [31:0] d);
    rd_req = 1; rd_addr = 32'h0003_2000 | (32'(a) << 2);
    step();
    rd_req = 0;
    d = rd_data;
  endtask

  initial begin
    bit [31:0] v;
    bit [1:0]  a;
    rst = 1; rd_req = 0; wr_req = 0; rd_be = 4'hf; wr_be = 4'hf;
    rd_addr = 0; wr_addr = 0; wr_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // T1: reset values
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      chk("t1_reg", v, 32'h0);
    end
    chk("t1_irq", irq, 0);

    // T2: auto-reload, LOAD=3, PRESCALE=0
    wr(2'd1, 32'd3, 4'hf);
    wr(2'd0, 32'h7, 4'hf);
    for (int i = 0; i < 13; i++) begin
      chk("t2_tick", tick, (i % 4 == 0) ? 32'd1 : 32'd0);
      if (i == 1) chk("t2_irq_low", irq, 0);
      if (i == 2) chk("t2_irq_high", irq, 1);
      step();
    end
    rd(2'd3, v); chk("t2_status", v, 32'h3);
    rd(2'd1, v); chk("t2_load", v, 32'h3);
    wr(2'd0, 32'h0, 4'hf);
    wr(2'd3, 32'h1, 4'hf);
    step();
    chk("t2_irq_off", irq, 0);

    // T3: one-shot, PRESCALE=2, COUNT=1
    wr(2'd2, 32'd1, 4'hf);
    wr(2'd0, 32'h0201, 4'hf);
    for (int i = 0; i < 9; i++) begin
      chk("t3_tick", tick, (i == 5) ? 32'd1 : 32'd0);
      step();
    end
    rd(2'd3, v); chk("t3_status", v, 32'h1);
    rd(2'd0, v); chk("t3_ctrl", v, 32'h0200);
    rd(2'd2, v); chk("t3_count", v, 32'h0);

    // T4: W1C colliding with a tick
    wr(2'd3, 32'h1, 4'hf);
    wr(2'd0, 32'h7, 4'hf);
    chk("t4_tick0", tick, 1);
    wr(2'd3, 32'h1, 4'hf);
    rd(2'd3, v); chk("t4_sticky", v, 32'h3);
    wr(2'd3, 32'h1, 4'hf);
    chk("t4_irq_hold", irq, 1);
    step();
    chk("t4_irq_drop", irq, 0);
    chk("t4_tick4", tick, 1);
    wr(2'd0, 32'h0, 4'hf);
    wr(2'd3, 32'h1, 4'hf);
    step();

    // T5: byte-lane write
    wr(2'd1, 32'h1234_5678, 4'hf);
    wr(2'd1, 32'hFFFF_FFAA, 4'b0001);
    rd(2'd1, v); chk("t5_load", v, 32'h1234_56AA);

    // T6: asynchronous reset mid-count
    wr(2'd2, 32'd5, 4'hf);
    wr(2'd0, 32'h5, 4'hf);
    step(); step();
    #2 rst = 1;
    #1;
    chk("t6_tick", tick, 0);
    chk("t6_irq", irq, 0);
    chk("t6_rd_data", rd_data, 0);
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      chk("t6_reg", v, 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      chk("t6_no_tick", tick, 0);
      step();
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rd_req  = ($urandom_range(0, 2) == 0);
      rd_addr = $urandom;
      wr_req  = ($urandom_range(0, 4) == 0);
      a       = 2'($urandom_range(0, 3));
      wr_addr = ($urandom & 32'hFFFF_FFF3) | (32'(a) << 2);
      wr_be   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
      case (a)
        2'd0:    wr_data = ($urandom & 32'hFFFF_00F8) | (32'($urandom_range(0, 3)) << 8)
                           | 32'($urandom_range(0, 7));
        2'd1,
        2'd2:    wr_data = 32'($urandom_range(0, 9));
        default: wr_data = $urandom;
      endcase
      if (n == 1500) begin
        #2 rst = 1;
        step();
        rst = 0;
      end else begin
        step();
      end
    end
    rd_req = 0; wr_req = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
